// File: rtl/queue_wr_arbiter.sv
// Round-robin arbiter sharing one QUEUE write port between two producers.
// Ports: CLK, INIT (sync high reset), REQ0/REQ1 + D0/D1 in, ACK0/ACK1 and
// GNT0/GNT1 out, Q_FULL in, Q_WR/Q_DI out to the queue write side.
module queue_wr_arbiter #(
   parameter int W     = 8,
   parameter int BURST = 4
) (
   input  logic         CLK,
   input  logic         INIT,
   input  logic         REQ0,
   input  logic         REQ1,
   input  logic [W-1:0] D0,
   input  logic [W-1:0] D1,
   output logic         ACK0,
   output logic         ACK1,
   output logic         GNT0,
   output logic         GNT1,
   input  logic         Q_FULL,
   output logic         Q_WR,
   output logic [W-1:0] Q_DI
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN0 = 2'd1;
   localparam logic [1:0] OWN1 = 2'd2;
   localparam logic [3:0] CMAX = 4'(BURST - 1);

   logic [1:0] state, state_n;
   logic [3:0] cnt, cnt_n;
   logic       last, last_n;
   logic       req_own, req_oth, wr;

   always_comb begin
      GNT0    = (state == OWN0);
      GNT1    = (state == OWN1);
      req_own = (GNT0 & REQ0) | (GNT1 & REQ1);
      req_oth = (GNT0 & REQ1) | (GNT1 & REQ0);
      // FULL and INIT gate the write in the same cycle
      wr      = req_own & ~Q_FULL & ~INIT;
      Q_WR    = wr;
      ACK0    = GNT0 & wr;
      ACK1    = GNT1 & wr;
      Q_DI    = GNT0 ? D0 : (GNT1 ? D1 : '0);
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      last_n  = last;
      unique case (1'b1)
         GNT0, GNT1: begin
            if (wr && cnt != CMAX) begin
               cnt_n = cnt + 4'd1;
            end else if (wr || !req_own) begin
               // burst end or release: hand over without a bubble
               cnt_n = '0;
               if (req_oth) begin
                  state_n = GNT0 ? OWN1 : OWN0;
                  last_n  = GNT0;
               end else if (!req_own) begin
                  state_n = IDLE;
               end
            end
            // otherwise stalled on FULL: hold everything
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            if (REQ0 && (!REQ1 || last)) begin
               state_n = OWN0;
               last_n  = 1'b0;
            end else if (REQ1) begin
               state_n = OWN1;
               last_n  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (INIT) begin
         state <= IDLE;
         cnt   <= '0;
         last  <= 1'b1;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         last  <= last_n;
      end
   end

endmodule

// File: tb/tb_queue_wr_arbiter.sv
// Bench for queue_wr_arbiter: behavioural 16-deep queue, two producers,
// and a write-order scoreboard filled by the directed steps.
module tb_queue_wr_arbiter;

   localparam int W     = 8;
   localparam int BURST = 4;

   logic         CLK = 1'b0;
   logic         INIT, REQ0, REQ1, Q_FULL;
   logic [W-1:0] D0, D1;
   logic         ACK0, ACK1, GNT0, GNT1, Q_WR;
   logic [W-1:0] Q_DI;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] qmem[$];
   logic [W-1:0] exp_q[$];
   logic         rd;
   logic         en0, en1;
   int           base0, base1, idx0, idx1, rem0, rem1;

   always #5 CLK = ~CLK;

   queue_wr_arbiter #(.W(W), .BURST(BURST)) dut (
      .CLK(CLK), .INIT(INIT),
      .REQ0(REQ0), .REQ1(REQ1),
      .D0(D0), .D1(D1),
      .ACK0(ACK0), .ACK1(ACK1),
      .GNT0(GNT0), .GNT1(GNT1),
      .Q_FULL(Q_FULL), .Q_WR(Q_WR), .Q_DI(Q_DI)
   );

   task automatic chk1(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %b required %b", tag, obs, expv);
      end
   endtask

   task automatic chkw(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h required %h", tag, obs, expv);
      end
   endtask

   task automatic set_drive();
      REQ0   = en0 && rem0 > 0;
      REQ1   = en1 && rem1 > 0;
      D0     = W'(base0 + idx0);
      D1     = W'(base1 + idx1);
      Q_FULL = qmem.size() >= 16;
   endtask

   task automatic push_seq(input int base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(W'(base + i));
   endtask

   task automatic preload(input int n);
      for (int i = 0; i < n; i++) qmem.push_back(8'hEE);
      set_drive();
   endtask

   // One clock: sample outputs mid-cycle, then apply the edge to the models.
   task automatic tick();
      logic a0, a1, wr;
      logic [W-1:0] di;
      set_drive();
      #1;
      a0 = ACK0;
      a1 = ACK1;
      wr = Q_WR;
      di = Q_DI;
      chk1("ack_onehot", a0 & a1, 1'b0);
      chk1("wr_when_full", wr & Q_FULL, 1'b0);
      chk1("wr_vs_ack", wr, a0 | a1);
      if (wr) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_extra: observed write %h required none", di);
         end
         if (exp_q.size() != 0) chkw("sb_data", di, exp_q.pop_front());
      end
      @(posedge CLK);
      #1;
      if (rd && qmem.size() > 0) void'(qmem.pop_front());
      if (wr) qmem.push_back(di);
      if (a0) begin idx0++; rem0--; end
      if (a1) begin idx1++; rem1--; end
      set_drive();
      @(negedge CLK);
   endtask

   task automatic do_reset();
      INIT = 1'b1;
      en0 = 1'b0; en1 = 1'b0; rd = 1'b0;
      idx0 = 0; idx1 = 0; rem0 = 0; rem1 = 0;
      base0 = 0; base1 = 0;
      tick();
      chk1("sb_drained", exp_q.size() == 0, 1'b1);
      exp_q.delete();
      qmem.delete();
      INIT = 1'b0;
      set_drive();
      #1;
      chk1("rst_gnt0", GNT0, 1'b0);
      chk1("rst_gnt1", GNT1, 1'b0);
      chk1("rst_ack0", ACK0, 1'b0);
      chk1("rst_ack1", ACK1, 1'b0);
      chk1("rst_wr", Q_WR, 1'b0);
      chkw("rst_di", Q_DI, '0);
   endtask

   initial begin
      INIT = 1'b1;
      en0 = 1'b0; en1 = 1'b0; rd = 1'b0;
      idx0 = 0; idx1 = 0; rem0 = 0; rem1 = 0;
      base0 = 0; base1 = 0;
      set_drive();
      @(negedge CLK);

      // single producer fills the queue
      do_reset();
      base0 = 1; rem0 = 100; en0 = 1'b1;
      push_seq(1, 16);
      tick();
      chk1("t1_gnt0", GNT0, 1'b1);
      chk1("t1_gnt1", GNT1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         chk1("t1_ack0", ACK0, 1'b1);
         tick();
      end
      chk1("t1_full_wr", Q_WR, 1'b0);
      chk1("t1_full_ack", ACK0, 1'b0);
      chk1("t1_full_gnt", GNT0, 1'b1);
      tick();
      chk1("t1_full_wr2", Q_WR, 1'b0);
      en0 = 1'b0;

      // tie from reset: alternate bursts, producer 0 first
      do_reset();
      base1 = 8'h80; rem0 = 100; rem1 = 100; en0 = 1'b1; en1 = 1'b1;
      push_seq(8'h00, 4); push_seq(8'h80, 4);
      push_seq(8'h04, 4); push_seq(8'h84, 4);
      tick();
      for (int k = 0; k < 16; k++) begin
         chk1("t2_gnt0", GNT0, ((k / 4) % 2) == 0);
         chk1("t2_gnt1", GNT1, ((k / 4) % 2) == 1);
         chk1("t2_ack", ((k / 4) % 2) == 0 ? ACK0 : ACK1, 1'b1);
         tick();
      end
      en0 = 1'b0; en1 = 1'b0;

      // early release after 2 words, then full burst for producer 1
      do_reset();
      base0 = 8'h10; rem0 = 2; en0 = 1'b1;
      base1 = 8'h90; rem1 = 100; en1 = 1'b1;
      push_seq(8'h10, 2); push_seq(8'h90, 4); push_seq(8'h12, 4);
      tick();
      for (int i = 0; i < 2; i++) begin
         chk1("t3_ack0", ACK0, 1'b1);
         tick();
      end
      chk1("t3_rel_gnt0", GNT0, 1'b1);
      chk1("t3_rel_wr", Q_WR, 1'b0);
      tick();
      chk1("t3_gnt1", GNT1, 1'b1);
      rem0 = 100;
      for (int i = 0; i < 4; i++) begin
         chk1("t3_ack1", ACK1, 1'b1);
         chk1("t3_gnt1_hold", GNT1, 1'b1);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         chk1("t3_back_gnt0", GNT0, 1'b1);
         chk1("t3_back_ack0", ACK0, 1'b1);
         tick();
      end
      en0 = 1'b0; en1 = 1'b0;

      // full stall mid-burst for producer 1
      do_reset();
      preload(14);
      base1 = 8'hA0; rem1 = 100; en1 = 1'b1;
      push_seq(8'hA0, 4);
      tick();
      chk1("t4_gnt1", GNT1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         chk1("t4_ack1", ACK1, 1'b1);
         tick();
      end
      base0 = 8'h30; rem0 = 100; en0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk1("t4_stall_wr", Q_WR, 1'b0);
         chk1("t4_stall_ack1", ACK1, 1'b0);
         chk1("t4_stall_gnt1", GNT1, 1'b1);
         chk1("t4_stall_gnt0", GNT0, 1'b0);
         tick();
      end
      rd = 1'b1;
      chk1("t4_rd_full_ack1", ACK1, 1'b0);
      tick();
      chk1("t4_resume_ack1", ACK1, 1'b1);
      tick();
      chk1("t4_last_ack1", ACK1, 1'b1);
      chk1("t4_last_gnt1", GNT1, 1'b1);
      tick();
      chk1("t4_handover_gnt0", GNT0, 1'b1);
      en0 = 1'b0; en1 = 1'b0; rd = 1'b0;
      tick();

      // simultaneous read and write at 15 entries
      do_reset();
      preload(15);
      base0 = 8'h40; rem0 = 100; en0 = 1'b1;
      push_seq(8'h40, 12);
      tick();
      rd = 1'b1;
      for (int i = 0; i < 12; i++) begin
         chk1("t5_ack0", ACK0, 1'b1);
         chk1("t5_wr", Q_WR, 1'b1);
         tick();
      end
      en0 = 1'b0; rd = 1'b0;

      // reset in cycle 2 of a burst
      do_reset();
      base0 = 8'h50; rem0 = 100; en0 = 1'b1;
      push_seq(8'h50, 1); push_seq(8'h51, 4);
      tick();
      chk1("t6_ack0", ACK0, 1'b1);
      tick();
      INIT = 1'b1;
      #1;
      chk1("t6_init_ack0", ACK0, 1'b0);
      chk1("t6_init_wr", Q_WR, 1'b0);
      chk1("t6_init_gnt0", GNT0, 1'b1);
      tick();
      INIT = 1'b0;
      base1 = 8'hD0; rem1 = 100; en1 = 1'b1;
      set_drive();
      #1;
      chk1("t6_idle_gnt0", GNT0, 1'b0);
      chk1("t6_idle_gnt1", GNT1, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk1("t6_tie_gnt0", GNT0, 1'b1);
         chk1("t6_tie_ack0", ACK0, 1'b1);
         tick();
      end
      en0 = 1'b0; en1 = 1'b0;
      tick();
      chk1("final_drained", exp_q.size() == 0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
